rvskidbuf: RTL and testbench
============================

RVSKIDBUF -- requirements
Module: rvskidbuf

Interface
REQ-001 Parameter WIDTH, default 3, payload width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 flush  input  1  synchronous discard of all buffered entries.
REQ-005 in_valid  input  1  upstream offers in_data.
REQ-006 in_data  input  WIDTH  upstream payload.
REQ-007 in_ready  output  1  buffer can accept; driven only from registered state.
REQ-008 out_valid  output  1  out_data holds a valid entry.
REQ-009 out_data  output  WIDTH  head payload, driven directly from the main register.
REQ-010 out_ready  input  1  downstream accepts out_data.
REQ-011 count  output  2  number of held entries, 0..2.

Function
REQ-012 Input transfer SHALL occur when in_valid and in_ready are both 1 at a rising edge; output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-013 States SHALL be EMPTY (count 0), ONE (main register valid), FULL (main and skid registers valid).
REQ-014 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL; it SHALL have no combinational path from out_ready, in_valid or flush.
REQ-015 out_valid SHALL be 1 in ONE and FULL; there SHALL be no combinational path from in_valid or in_data to any output.
REQ-016 EMPTY: input transfer -> main <= in_data, go to ONE; otherwise stay.
REQ-017 ONE: input and output transfer together -> main <= in_data, stay in ONE; input only -> skid <= in_data, go to FULL; output only -> go to EMPTY.
REQ-018 FULL: output transfer -> main <= skid, go to ONE; otherwise hold both registers.
REQ-019 Latency SHALL be one cycle: data accepted at edge N appears on out_data with out_valid=1 after edge N when the buffer was EMPTY.
REQ-020 Order SHALL be strict FIFO; no entry is dropped or duplicated except by flush or rst.
REQ-021 flush=1 SHALL force state EMPTY and clear main and skid to 0 at the next edge, overriding any coincident input or output transfer; a coincident input transfer is discarded.
REQ-022 Full throughput: with in_valid and out_ready held at 1, one transfer per cycle SHALL occur each way and the state SHALL remain ONE.
REQ-023 count SHALL equal 0/1/2 for EMPTY/ONE/FULL, decoded from registered state.

Reset
REQ-024 rst=1 at a rising edge SHALL set state EMPTY, main and skid to 0, giving out_valid=0, out_data=0, in_ready=1, count=0.
REQ-025 rst SHALL take priority over flush and all transfers; any entry in flight during reset is lost.
REQ-026 No register SHALL use an asynchronous reset.

Structure
REQ-027 The shared package rvskidbuf_pkg SHALL hold the state enum (EMPTY=2'b00, ONE=2'b01, FULL=2'b10) and the count width constant.
REQ-028 Data storage SHALL use one sub-module, rvdffe_sr (WIDTH-parameterised enabled flop with synchronous active-high clear), instantiated twice (main, skid).
REQ-029 The state register SHALL be in the top module; encoding 2'b11 is illegal and SHALL map to EMPTY.

Verification
REQ-030 After rst: in_valid=1, in_data=3'b101, out_ready=0 for one edge -> out_valid=1, out_data=3'b101, count=1, in_ready=1.
REQ-031 Continue in_data=3'b011, out_ready=0 -> count=2, in_ready=0; then out_ready=1 for two edges, in_valid=0 -> out_data 3'b101 then 3'b011, then EMPTY.
REQ-032 in_valid=1 and out_ready=1 for 8 cycles with data 0..7 -> out_data 0..7 in order, one per cycle, count stays 1.
REQ-033 FULL with in_valid=1 and flush=1 -> next cycle count=0, out_valid=0, out_data=0, in_ready=1; flushed data never appears.
REQ-034 rst asserted in FULL with flush=1 and out_ready=1 -> all outputs equal reset values next cycle.
REQ-035 Random in_valid/out_ready over 10k cycles -> scoreboard FIFO order, no loss/duplication, in_ready never 1 when count=2.

Source files
------------

// File: rtl/rvskidbuf_pkg.sv
// Shared definitions for the rvskidbuf two-entry ready/valid skid buffer.
//   state_e      : occupancy state of the buffer (EMPTY / ONE / FULL)
//   CountWidth   : width of the occupancy count output
//   state_count(): maps a state to its occupancy count
package rvskidbuf_pkg;

    localparam int unsigned CountWidth = 2;

    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b01,
        StFull  = 2'b10
    } state_e;

    function automatic logic [CountWidth-1:0] state_count(input state_e st);
        logic [CountWidth-1:0] cnt;
        cnt = '0;
        case (st)
            StOne:   cnt = CountWidth'(1);
            StFull:  cnt = CountWidth'(2);
            default: cnt = '0;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/rvdffe_sr.sv
// Enabled flop bank with synchronous active-high clear.
//   clk : clock
//   clr : synchronous clear to zero, wins over en
//   en  : load d on the rising edge
//   d   : next value
//   q   : registered value
module rvdffe_sr #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/rvskidbuf.sv
// Two-entry ready/valid skid buffer. in_ready depends only on registered state, so the
// upstream handshake is fully decoupled from downstream backpressure.
//   clk, rst  : clock, synchronous active-high reset
//   flush     : synchronous discard of all held entries
//   in_valid, in_data, in_ready    : upstream handshake
//   out_valid, out_data, out_ready : downstream handshake (out_data is the main register)
//   count     : number of held entries (0..2)
module rvskidbuf
    import rvskidbuf_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    input  logic                  out_ready,
    output logic [CountWidth-1:0] count
);

    logic [1:0]       state_q;
    state_e           state_d;
    state_e           st;
    logic             in_xfer;
    logic             out_xfer;
    logic             main_en;
    logic             skid_en;
    logic             data_clr;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    // The unused encoding 2'b11 decodes as EMPTY so a corrupted state self-recovers.
    assign st = (state_q == 2'b11) ? StEmpty : state_e'(state_q);

    assign in_ready  = (st != StFull);
    assign out_valid = (st != StEmpty);
    assign out_data  = main_q;
    assign count     = state_count(st);

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;
    assign data_clr = rst | flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = st;
        main_en = 1'b0;
        skid_en = 1'b0;
        // Only FULL refills main from skid; every other load comes from upstream.
        main_d  = (st == StFull) ? skid_q : in_data;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            case (st)
                StEmpty: begin
                    if (in_xfer) begin
                        main_en = 1'b1;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (in_xfer && out_xfer) begin
                        main_en = 1'b1;
                    end else if (in_xfer) begin
                        skid_en = 1'b1;
                        state_d = StFull;
                    end else if (out_xfer) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (out_xfer) begin
                        main_en = 1'b1;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    rvdffe_sr #(
        .WIDTH(WIDTH)
    ) u_main (
        .clk(clk),
        .clr(data_clr),
        .en (main_en),
        .d  (main_d),
        .q  (main_q)
    );

    rvdffe_sr #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk(clk),
        .clr(data_clr),
        .en (skid_en),
        .d  (in_data),
        .q  (skid_q)
    );

endmodule

// File: tb/tb_rvskidbuf.sv
module tb_rvskidbuf;

    localparam int unsigned W = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready = 1'b0;
    logic [1:0]   count;

    int checks = 0;
    int failures = 0;

    // Scoreboard: entries the buffer should hold, head first.
    logic [W-1:0] exp_q[$];
    // Set after rst/flush until the next accepted entry: out_data must read zero.
    bit           data_zero = 1'b0;

    always #5 clk = ~clk;

    rvskidbuf #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .count    (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int n;
        n = exp_q.size();
        chk("count", 32'(count), 32'(n));
        chk("in_ready", 32'(in_ready), 32'(n < 2));
        chk("out_valid", 32'(out_valid), 32'(n > 0));
        if (n > 0) chk("out_data", 32'(out_data), 32'(exp_q[0]));
        else if (data_zero) chk("out_data_zero", 32'(out_data), 32'd0);
    endtask

    // Inputs are stable at the falling edge; the model decides the transfers from its own
    // occupancy, then outputs are checked half a cycle after the rising edge.
    task automatic tick();
        bit do_pop;
        bit do_push;
        do_pop  = out_ready && (exp_q.size() > 0);
        do_push = in_valid && (exp_q.size() < 2);
        @(posedge clk);
        if (rst || flush) begin
            exp_q.delete();
            data_zero = 1'b1;
        end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) begin
                exp_q.push_back(in_data);
                data_zero = 1'b0;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive(input bit v, input logic [W-1:0] d, input bit r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    initial begin
        @(negedge clk);
        // Reset
        rst = 1'b1;
        drive(1'b0, '0, 1'b0);
        tick();
        rst = 1'b0;

        // Accept one entry, then fill, then drain in order
        drive(1'b1, 3'b101, 1'b0);
        tick();
        chk("first_data", 32'(out_data), 32'h5);
        drive(1'b1, 3'b011, 1'b0);
        tick();
        chk("full_count", 32'(count), 32'd2);
        drive(1'b1, 3'b111, 1'b0);
        tick();  // held off while FULL, 3'b111 must not enter
        drive(1'b0, '0, 1'b1);
        tick();
        chk("drain1", 32'(out_data), 32'h3);
        tick();
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Full throughput
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, W'(i), 1'b1);
            tick();
            chk("stream_count", 32'(count), 32'd1);
        end
        drive(1'b0, '0, 1'b1);
        tick();

        // Flush from FULL with a coincident input
        drive(1'b1, 3'b001, 1'b0);
        tick();
        drive(1'b1, 3'b010, 1'b0);
        tick();
        flush = 1'b1;
        drive(1'b1, 3'b110, 1'b1);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, 1'b1);
        tick();

        // Reset dominates flush and transfers in FULL
        drive(1'b1, 3'b100, 1'b0);
        tick();
        drive(1'b1, 3'b101, 1'b0);
        tick();
        rst   = 1'b1;
        flush = 1'b1;
        drive(1'b1, 3'b111, 1'b1);
        tick();
        rst   = 1'b0;
        flush = 1'b0;
        drive(1'b0, '0, 1'b0);
        tick();

        // Random handshakes
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(1)), W'($urandom), 1'($urandom_range(1)));
            tick();
        end
        drive(1'b0, '0, 1'b1);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
